// File: rtl/bp_update_ctrl.sv
// In-order branch resolution controller: tracks predicted branches in a FIFO,
// trains the predictor on retirement and recovers fetch/history on mispredicts.
module bp_update_ctrl #(
  parameter int DEPTH = 4,
  parameter int GHR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     f_valid,
  output logic                     f_ready,
  input  logic [31:0]              f_pc,
  input  logic                     f_pred,
  input  logic [31:0]              f_target,
  input  logic [GHR_W-1:0]         f_ghr,
  input  logic                     r_valid,
  input  logic                     r_taken,
  input  logic [31:0]              r_target,
  output logic                     upd_en,
  output logic                     upd_taken,
  output logic [31:0]              upd_pc,
  output logic [GHR_W-1:0]         upd_ghr,
  output logic                     flush,
  output logic [31:0]              redirect_pc,
  output logic                     ghr_restore_en,
  output logic [GHR_W-1:0]         ghr_restore,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              br_count,
  output logic [15:0]              mp_count,
  output logic                     err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } state_t;

  state_t state_r, state_nxt_s;

  logic [31:0]      pc_mem_r   [DEPTH];
  logic             pred_mem_r [DEPTH];
  logic [31:0]      tgt_mem_r  [DEPTH];
  logic [GHR_W-1:0] ghr_mem_r  [DEPTH];

  logic [PTR_W-1:0] head_r, tail_r, head_nxt_s, tail_nxt_s;
  logic [CNT_W-1:0] count_r, count_nxt_s;

  logic             alloc_s, resolve_s, empty_res_s, mispredict_s;
  logic [31:0]      head_pc_s, head_tgt_s;
  logic             head_pred_s;
  logic [GHR_W-1:0] head_ghr_s;

  assign count = count_r;

  // Head-entry view and handshake decode; resolves are ignored during recovery
  always_comb begin
    head_pc_s    = pc_mem_r[head_r];
    head_pred_s  = pred_mem_r[head_r];
    head_tgt_s   = tgt_mem_r[head_r];
    head_ghr_s   = ghr_mem_r[head_r];
    f_ready      = (state_r == RUN) && (count_r < FULL_CNT);
    alloc_s      = f_valid && f_ready;
    resolve_s    = r_valid && (state_r == RUN) && (count_r != CNT_ZERO);
    empty_res_s  = r_valid && (state_r == RUN) && (count_r == CNT_ZERO);
    mispredict_s = resolve_s &&
                   ((r_taken != head_pred_s) ||
                    (r_taken && head_pred_s && (r_target != head_tgt_s)));
  end

  // Next-state, pointer and occupancy logic
  always_comb begin
    state_nxt_s = state_r;
    head_nxt_s  = head_r;
    tail_nxt_s  = tail_r;
    count_nxt_s = count_r;
    case (state_r)
      RUN: begin
        if (mispredict_s) begin
          // squash everything younger, including a same-cycle allocation
          state_nxt_s = RECOVER;
          head_nxt_s  = tail_r;
          count_nxt_s = CNT_ZERO;
        end else begin
          if (resolve_s) begin
            head_nxt_s = head_r + PTR_ONE;
          end else begin
            head_nxt_s = head_r;
          end
          if (alloc_s) begin
            tail_nxt_s = tail_r + PTR_ONE;
          end else begin
            tail_nxt_s = tail_r;
          end
          if (alloc_s && !resolve_s) begin
            count_nxt_s = count_r + CNT_ONE;
          end else if (resolve_s && !alloc_s) begin
            count_nxt_s = count_r - CNT_ONE;
          end else begin
            count_nxt_s = count_r;
          end
        end
      end
      RECOVER: begin
        state_nxt_s = RUN;
      end
      default: begin
        state_nxt_s = RUN;
      end
    endcase
  end

  // State, pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RUN;
      head_r  <= PTR_ZERO;
      tail_r  <= PTR_ZERO;
      count_r <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      head_r  <= head_nxt_s;
      tail_r  <= tail_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  // Entry storage; stale slots are never read because head/count gate them
  always_ff @(posedge clk) begin
    if (alloc_s) begin
      pc_mem_r[tail_r]   <= f_pc;
      pred_mem_r[tail_r] <= f_pred;
      tgt_mem_r[tail_r]  <= f_target;
      ghr_mem_r[tail_r]  <= f_ghr;
    end
  end

  // Registered update, recovery and statistics outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      upd_en         <= 1'b0;
      upd_taken      <= 1'b0;
      upd_pc         <= 32'd0;
      upd_ghr        <= {GHR_W{1'b0}};
      flush          <= 1'b0;
      redirect_pc    <= 32'd0;
      ghr_restore_en <= 1'b0;
      ghr_restore    <= {GHR_W{1'b0}};
      br_count       <= 16'd0;
      mp_count       <= 16'd0;
      err            <= 1'b0;
    end else begin
      upd_en         <= resolve_s;
      flush          <= mispredict_s;
      ghr_restore_en <= mispredict_s;
      if (resolve_s) begin
        upd_taken <= r_taken;
        upd_pc    <= head_pc_s;
        upd_ghr   <= head_ghr_s;
        if (br_count != 16'hFFFF) begin
          br_count <= br_count + 16'd1;
        end
      end
      if (mispredict_s) begin
        redirect_pc <= r_taken ? r_target : (head_pc_s + 32'd4);
        ghr_restore <= {head_ghr_s[GHR_W-2:0], r_taken};
        if (mp_count != 16'hFFFF) begin
          mp_count <= mp_count + 16'd1;
        end
      end
      if (empty_res_s) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Directed bench for bp_update_ctrl with a queue-based FIFO model and an
// update scoreboard checked one cycle after every resolve.
module tb_bp_update_ctrl;

  localparam int DEPTH = 4;
  localparam int GHR_W = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             f_valid, f_ready, f_pred;
  logic [31:0]      f_pc, f_target;
  logic [GHR_W-1:0] f_ghr;
  logic             r_valid, r_taken;
  logic [31:0]      r_target;
  logic             upd_en, upd_taken, flush, ghr_restore_en, err;
  logic [31:0]      upd_pc, redirect_pc;
  logic [GHR_W-1:0] upd_ghr, ghr_restore;
  logic [CNT_W-1:0] count;
  logic [15:0]      br_count, mp_count;

  bp_update_ctrl #(.DEPTH(DEPTH), .GHR_W(GHR_W)) dut (
    .clk(clk), .rst(rst),
    .f_valid(f_valid), .f_ready(f_ready), .f_pc(f_pc), .f_pred(f_pred),
    .f_target(f_target), .f_ghr(f_ghr),
    .r_valid(r_valid), .r_taken(r_taken), .r_target(r_target),
    .upd_en(upd_en), .upd_taken(upd_taken), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
    .flush(flush), .redirect_pc(redirect_pc),
    .ghr_restore_en(ghr_restore_en), .ghr_restore(ghr_restore),
    .count(count), .br_count(br_count), .mp_count(mp_count), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      pc;
    logic             taken;
    logic [GHR_W-1:0] ghr;
    logic             flush;
    logic [31:0]      redirect;
    logic [GHR_W-1:0] restore;
  } exp_t;

  typedef struct {
    logic [31:0]      pc;
    logic             pred;
    logic [31:0]      target;
    logic [GHR_W-1:0] ghr;
  } ent_t;

  exp_t        sb[$];
  ent_t        model[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic        in_recover = 1'b0;
  logic        exp_err = 1'b0;
  logic [15:0] exp_br = 16'd0;
  logic [15:0] exp_mp = 16'd0;
  logic [31:0] pcn;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare the update/recovery outputs against the scoreboard head
  task automatic monitor();
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("upd_en", 32'(upd_en), 32'd1);
      chk("upd_pc", upd_pc, e.pc);
      chk("upd_taken", 32'(upd_taken), 32'(e.taken));
      chk("upd_ghr", 32'(upd_ghr), 32'(e.ghr));
      chk("flush", 32'(flush), 32'(e.flush));
      chk("ghr_restore_en", 32'(ghr_restore_en), 32'(e.flush));
      if (e.flush) begin
        chk("redirect_pc", redirect_pc, e.redirect);
        chk("ghr_restore", 32'(ghr_restore), 32'(e.restore));
      end
    end else begin
      chk("upd_en_idle", 32'(upd_en), 32'd0);
      chk("flush_idle", 32'(flush), 32'd0);
      chk("ghr_restore_en_idle", 32'(ghr_restore_en), 32'd0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
  endtask

  // Advance the model with the currently driven inputs, then clock the DUT
  task automatic step();
    exp_t e;
    ent_t h;
    ent_t n;
    logic mp;
    logic acc;
    logic exp_rdy;
    exp_rdy = !in_recover && (model.size() < DEPTH);
    chk("f_ready", 32'(f_ready), 32'(exp_rdy));
    mp = 1'b0;
    if (rst) begin
      model.delete();
      sb.delete();
      in_recover = 1'b0;
      exp_err = 1'b0;
      exp_br = 16'd0;
      exp_mp = 16'd0;
    end else begin
      acc = f_valid && exp_rdy;
      if (r_valid && !in_recover && model.size() == 0) exp_err = 1'b1;
      if (r_valid && !in_recover && model.size() > 0) begin
        h = model.pop_front();
        mp = (r_taken != h.pred) || (r_taken && h.pred && (r_target != h.target));
        e.pc = h.pc;
        e.taken = r_taken;
        e.ghr = h.ghr;
        e.flush = mp;
        e.redirect = r_taken ? r_target : (h.pc + 32'd4);
        e.restore = {h.ghr[GHR_W-2:0], r_taken};
        sb.push_back(e);
        if (exp_br != 16'hFFFF) exp_br = exp_br + 16'd1;
        if (mp && exp_mp != 16'hFFFF) exp_mp = exp_mp + 16'd1;
      end
      if (mp) begin
        model.delete();
      end else if (acc) begin
        n.pc = f_pc;
        n.pred = f_pred;
        n.target = f_target;
        n.ghr = f_ghr;
        model.push_back(n);
      end
      in_recover = mp;
    end
    tick();
    chk("count", 32'(count), 32'(model.size()));
    chk("err", 32'(err), 32'(exp_err));
    chk("br_count", 32'(br_count), 32'(exp_br));
    chk("mp_count", 32'(mp_count), 32'(exp_mp));
  endtask

  task automatic drive_alloc(input logic [31:0] pc, input logic pred,
                             input logic [31:0] tgt, input logic [GHR_W-1:0] ghr);
    f_valid = 1'b1;
    f_pc = pc;
    f_pred = pred;
    f_target = tgt;
    f_ghr = ghr;
  endtask

  task automatic drive_res(input logic taken, input logic [31:0] tgt);
    r_valid = 1'b1;
    r_taken = taken;
    r_target = tgt;
  endtask

  task automatic idle();
    f_valid = 1'b0;
    r_valid = 1'b0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_upd_en", 32'(upd_en), 32'd0);
    chk("rst_upd_taken", 32'(upd_taken), 32'd0);
    chk("rst_upd_pc", upd_pc, 32'd0);
    chk("rst_upd_ghr", 32'(upd_ghr), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_ghr_restore_en", 32'(ghr_restore_en), 32'd0);
    chk("rst_ghr_restore", 32'(ghr_restore), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_br_count", 32'(br_count), 32'd0);
    chk("rst_mp_count", 32'(mp_count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_f_ready", 32'(f_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    f_valid = 1'b0; f_pc = 32'd0; f_pred = 1'b0; f_target = 32'd0; f_ghr = 8'd0;
    r_valid = 1'b0; r_taken = 1'b0; r_target = 32'd0;
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;
    check_reset_outputs();

    // Fill to DEPTH; a fifth allocation must be refused
    for (int i = 0; i < 4; i++) begin
      drive_alloc(32'h100 + 32'(4 * i), 1'b0, 32'h0, 8'(8'h10 + i));
      step();
    end
    chk("full_f_ready", 32'(f_ready), 32'd0);
    drive_alloc(32'h110, 1'b0, 32'h0, 8'hEE);
    step();
    idle();

    // Drain with correct not-taken resolves
    for (int i = 0; i < 4; i++) begin
      drive_res(1'b0, 32'h0);
      step();
    end
    idle();
    chk("drain_br_count", 32'(br_count), 32'd4);
    chk("drain_count", 32'(count), 32'd0);

    // Direction mispredict: not-taken predicted, taken resolved
    drive_alloc(32'h200, 1'b0, 32'h0, 8'h5A);
    step();
    idle();
    drive_res(1'b1, 32'h400);
    step();
    chk("mp1_redirect", redirect_pc, 32'h400);
    chk("mp1_restore", 32'(ghr_restore), 32'hB5);
    chk("mp1_mp_count", 32'(mp_count), 32'd1);
    drive_res(1'b1, 32'h999);
    step();
    idle();
    step();

    // Target mispredict squashes younger entries and a same-cycle allocation
    drive_alloc(32'h300, 1'b1, 32'h500, 8'h11);
    step();
    drive_alloc(32'h304, 1'b0, 32'h0, 8'h22);
    step();
    drive_alloc(32'h308, 1'b0, 32'h0, 8'h33);
    step();
    drive_alloc(32'h30C, 1'b0, 32'h0, 8'h44);
    drive_res(1'b1, 32'h504);
    step();
    chk("mp2_redirect", redirect_pc, 32'h504);
    chk("mp2_count", 32'(count), 32'd0);
    idle();
    repeat (3) step();

    // Full FIFO with simultaneous allocate and correct resolve, wrapping pointers
    pcn = 32'h600;
    for (int i = 0; i < 4; i++) begin
      drive_alloc(pcn, 1'b0, 32'h0, pcn[9:2]);
      pcn = pcn + 32'd4;
      step();
    end
    for (int i = 0; i < 10; i++) begin
      drive_alloc(pcn, 1'b0, 32'h0, pcn[9:2]);
      drive_res(1'b0, 32'h0);
      if (model.size() < DEPTH) pcn = pcn + 32'd4;
      step();
    end
    f_valid = 1'b0;
    while (model.size() > 0) begin
      drive_res(1'b0, 32'h0);
      step();
    end
    idle();
    step();

    // Resolve while empty sets a sticky error
    drive_res(1'b0, 32'h0);
    step();
    idle();
    step();
    chk("err_sticky", 32'(err), 32'd1);

    // Reset during recovery
    drive_alloc(32'h700, 1'b0, 32'h0, 8'h77);
    step();
    idle();
    drive_res(1'b1, 32'h800);
    step();
    rst = 1'b1;
    drive_alloc(32'h704, 1'b0, 32'h0, 8'h01);
    drive_res(1'b1, 32'h900);
    step();
    rst = 1'b0;
    idle();
    check_reset_outputs();
    step();

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
